int_req_arbiter: RTL

//   Shares the single interrupt request channel (valid/ready, 64b addr + 32b data)

---
 rtl/int_req_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/int_req_arbiter.sv
// Round-robin arbiter sharing one MSI-X interrupt request channel among NUM_SRC
// requesters, with per-source masking and a single registered output slot.
module int_req_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int SRC_IDX_W = 2
) (
    input  logic                    dma_clk,
    input  logic                    rst_n,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [NUM_SRC*64-1:0]   src_addr,
    input  logic [NUM_SRC*32-1:0]   src_data,
    input  logic [NUM_SRC-1:0]      src_mask,
    output logic [NUM_SRC-1:0]      src_ready,
    output logic                    int_req_valid,
    output logic [63:0]             int_req_addr,
    output logic [31:0]             int_req_data,
    input  logic                    int_req_ready,
    output logic [SRC_IDX_W-1:0]    int_grant_idx,
    output logic                    int_busy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid is held with stable payload until then and never depends on ready.

    logic [NUM_SRC-1:0]   eligible;
    logic                 any_eligible;
    logic                 load_en;
    logic                 accept;
    logic [SRC_IDX_W-1:0] rr_ptr;
    logic [SRC_IDX_W-1:0] winner;
    logic                 found;
    int                   scan_idx;

    assign eligible     = src_valid & ~src_mask;
    assign any_eligible = |eligible;
    assign load_en      = ~int_req_valid | int_req_ready;
    // Gating with rst_n keeps a source from seeing an accept that reset would discard.
    assign accept       = rst_n & load_en & any_eligible;
    assign int_busy     = int_req_valid | any_eligible;

    // First eligible index at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_SRC) begin
                scan_idx = scan_idx - NUM_SRC;
            end
            if (!found && eligible[scan_idx]) begin
                found  = 1'b1;
                winner = SRC_IDX_W'(scan_idx);
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (accept) begin
            src_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge dma_clk or negedge rst_n) begin
        if (!rst_n) begin
            int_req_valid <= 1'b0;
            int_req_addr  <= '0;
            int_req_data  <= '0;
            int_grant_idx <= '0;
            rr_ptr        <= '0;
        end else if (accept) begin
            int_req_valid <= 1'b1;
            int_req_addr  <= src_addr[int'(winner)*64 +: 64];
            int_req_data  <= src_data[int'(winner)*32 +: 32];
            int_grant_idx <= winner;
            rr_ptr        <= (winner == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
        end else if (int_req_ready) begin
            int_req_valid <= 1'b0;
        end
    end

endmodule
